// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
//   arb_state_e : arbiter FSM states
//   FIXED/INCR/WRAP : AXI burst-type encodings
//   idx_width() : width of a requester index for n requesters
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  // Index width for n requesters; never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority position for this pick
//   grant : one-hot winner (zero when no request)
//   idx   : index of the winner
//   any   : at least one request present
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from ptr upward, wrapping modulo N; first hit wins.
  always_comb begin
    int unsigned pos;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(ptr) + k) % N;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel (AR + R) between NREQ
// requesters, one outstanding burst at a time.
//   clk, resetn          : clock, asynchronous active-low reset
//   req_ar*              : packed per-requester AR fields, requester i at [i*W +: W]
//   req_arvalid/arready  : per-requester AR handshake (arready one-hot, IDLE only)
//   req_rdata/rlast      : broadcast R payload
//   req_rvalid/rready    : per-requester R handshake, steered to grant_id
//   m_ar*, m_r*          : master-side AXI read channel
//   grant_id, busy       : current owner and in-flight indication
//   proto_err            : sticky beat-count / rlast mismatch flag
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 64,
  parameter int unsigned IW   = idx_width(NREQ)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ*AW-1:0] req_araddr,
  input  logic [NREQ*8-1:0] req_arlen,
  input  logic [NREQ*3-1:0] req_arsize,
  input  logic [NREQ*2-1:0] req_arburst,
  input  logic [NREQ-1:0]   req_arvalid,
  output logic [NREQ-1:0]   req_arready,
  output logic [DW-1:0]     req_rdata,
  output logic              req_rlast,
  output logic [NREQ-1:0]   req_rvalid,
  input  logic [NREQ-1:0]   req_rready,
  output logic [AW-1:0]     m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DW-1:0]     m_rdata,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [IW-1:0]     grant_id,
  output logic              busy,
  output logic              proto_err
);

  localparam int unsigned LW = 8;
  localparam int unsigned SW = 3;
  localparam int unsigned BW = 2;

  arb_state_e      state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [LW-1:0]   beat_cnt;
  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            accept;
  logic            beat;
  logic            rready_sel;

  logic [AW-1:0] addr_arr  [NREQ];
  logic [LW-1:0] len_arr   [NREQ];
  logic [SW-1:0] size_arr  [NREQ];
  logic [BW-1:0] burst_arr [NREQ];

  // Unpack the flat request buses into per-requester arrays.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_araddr[i*AW +: AW];
    assign len_arr[i]   = req_arlen[i*LW +: LW];
    assign size_arr[i]  = req_arsize[i*SW +: SW];
    assign burst_arr[i] = req_arburst[i*BW +: BW];
  end

  rr_picker #(
    .N  (NREQ),
    .IW (IW)
  ) u_picker (
    .req   (req_arvalid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and handshake decode. arready is gated by resetn so no
  // requester sees an acceptance while reset is held.
  always_comb begin
    state_nxt   = state;
    req_arready = '0;
    req_rvalid  = '0;
    m_arvalid   = 1'b0;
    rready_sel  = 1'b0;
    accept      = 1'b0;
    beat        = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any && resetn) begin
          req_arready = pick_grant;
          accept      = 1'b1;
          state_nxt   = ADDR;
        end
      end
      ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_nxt = DATA;
      end
      DATA: begin
        rready_sel           = req_rready[grant_id];
        req_rvalid[grant_id] = m_rvalid;
        beat                 = m_rvalid & rready_sel;
        if (beat && m_rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m_rready  = rready_sel;
  assign req_rdata = m_rdata;
  assign req_rlast = m_rlast;
  assign busy      = (state != IDLE);

  // AR capture, owner tracking, beat checking and round-robin pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
      grant_id  <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (accept) begin
        m_araddr  <= addr_arr[pick_idx];
        m_arlen   <= len_arr[pick_idx];
        m_arsize  <= size_arr[pick_idx];
        m_arburst <= burst_arr[pick_idx];
        grant_id  <= pick_idx;
        beat_cnt  <= len_arr[pick_idx];
      end
      if (beat) begin
        if (m_rlast) begin
          if (beat_cnt != '0) proto_err <= 1'b1;
          rr_ptr <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
        end else begin
          // Counter holds at zero on overrun; only the flag records it.
          if (beat_cnt == '0) proto_err <= 1'b1;
          else                beat_cnt  <= beat_cnt - LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: scoreboard queues of expected
// AR transfers and R beats, one task per scenario.
module tb_axi_read_arbiter;
  import axi_arb_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 64;
  localparam int unsigned IW   = 2;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NREQ*AW-1:0] req_araddr;
  logic [NREQ*8-1:0] req_arlen;
  logic [NREQ*3-1:0] req_arsize;
  logic [NREQ*2-1:0] req_arburst;
  logic [NREQ-1:0]   req_arvalid;
  logic [NREQ-1:0]   req_arready;
  logic [DW-1:0]     req_rdata;
  logic              req_rlast;
  logic [NREQ-1:0]   req_rvalid;
  logic [NREQ-1:0]   req_rready;
  logic [AW-1:0]     m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_arvalid;
  logic              m_arready;
  logic [DW-1:0]     m_rdata;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic              proto_err;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
  } ar_exp_t;

  typedef struct {
    logic [NREQ-1:0] rvalid;
    logic [DW-1:0]   data;
    logic            last;
  } r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];

  axi_read_arbiter #(
    .NREQ (NREQ), .AW (AW), .DW (DW), .IW (IW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_araddr  (req_araddr),
    .req_arlen   (req_arlen),
    .req_arsize  (req_arsize),
    .req_arburst (req_arburst),
    .req_arvalid (req_arvalid),
    .req_arready (req_arready),
    .req_rdata   (req_rdata),
    .req_rlast   (req_rlast),
    .req_rvalid  (req_rvalid),
    .req_rready  (req_rready),
    .m_araddr    (m_araddr),
    .m_arlen     (m_arlen),
    .m_arsize    (m_arsize),
    .m_arburst   (m_arburst),
    .m_arvalid   (m_arvalid),
    .m_arready   (m_arready),
    .m_rdata     (m_rdata),
    .m_rlast     (m_rlast),
    .m_rvalid    (m_rvalid),
    .m_rready    (m_rready),
    .grant_id    (grant_id),
    .busy        (busy),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b);
    req_araddr[i*AW +: AW] = a;
    req_arlen[i*8 +: 8]    = l;
    req_arsize[i*3 +: 3]   = s;
    req_arburst[i*2 +: 2]  = b;
    req_arvalid[i]         = 1'b1;
  endtask

  // Waits (bounded) for any arready; returns at the acceptance-cycle negedge.
  task automatic wait_accept(output logic [NREQ-1:0] vec, output bit ok);
    ok  = 1'b0;
    vec = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req_arready != '0) begin
        vec = req_arready;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    m_rvalid = 1'b1;
    m_rdata  = d;
    m_rlast  = last;
    @(negedge clk);
  endtask

  task automatic drive_beats(input int n);
    for (int k = 0; k < n; k++) begin
      m_rvalid = 1'b1;
      m_rdata  = DW'(k);
      m_rlast  = (k == n - 1);
      cyc();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({busy, m_arvalid, m_rready, proto_err, req_arready, req_rvalid, grant_id} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ctrl got busy=%b arv=%b rr=%b err=%b arr=%b rv=%b gid=%0d exp all 0",
               busy, m_arvalid, m_rready, proto_err, req_arready, req_rvalid, grant_id);
    end
    tests_run++;
    if ({m_araddr, m_arlen, m_arsize, m_arburst} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ar got addr=%h len=%0d size=%0d burst=%0d exp 0",
               m_araddr, m_arlen, m_arsize, m_arburst);
    end
    cyc();
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    logic [NREQ-1:0] vec;
    bit ok;
    ar_exp_t e;
    r_exp_t r;
    ar_q.push_back('{id: 2'd1, addr: 32'h1000, len: 8'd3, size: 3'd3, burst: INCR});
    set_req(1, 32'h1000, 8'd3, 3'd3, INCR);
    wait_accept(vec, ok);
    tests_run++;
    if (!ok || vec !== 4'b0010) begin
      tests_failed++;
      $display("FAIL single_arready got=%b ok=%0d exp=0010", vec, ok);
    end
    cyc();
    req_arvalid[1] = 1'b0;
    @(negedge clk);
    e = ar_q.pop_front();
    tests_run++;
    if (req_arready !== '0 || m_arvalid !== 1'b1 || m_araddr !== e.addr || m_arlen !== e.len ||
        m_arsize !== e.size || m_arburst !== e.burst || grant_id !== e.id || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_ar got arr=%b arv=%b addr=%h len=%0d size=%0d burst=%0d gid=%0d exp addr=%h len=%0d gid=%0d",
               req_arready, m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, grant_id, e.addr, e.len, e.id);
    end
    cyc();
    for (int b = 0; b < 4; b++) begin
      r_q.push_back('{rvalid: 4'b0010, data: 64'hA000 + 64'(b), last: (b == 3)});
      send_beat(64'hA000 + 64'(b), (b == 3));
      r = r_q.pop_front();
      tests_run++;
      if (req_rvalid !== r.rvalid || req_rdata !== r.data || req_rlast !== r.last || m_rready !== 1'b1) begin
        tests_failed++;
        $display("FAIL single_beat%0d got rv=%b d=%h l=%b mrr=%b exp rv=%b d=%h l=%b",
                 b, req_rvalid, req_rdata, req_rlast, m_rready, r.rvalid, r.data, r.last);
      end
      cyc();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || proto_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_end got busy=%b err=%b exp 0 0", busy, proto_err);
    end
    cyc();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] vec, exp_vec;
    bit ok;
    ar_exp_t e;
    int exp_id [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'h100 * (i + 1), 8'd0, 3'd2, INCR);
    for (int n = 0; n < 5; n++) begin
      ar_q.push_back('{id: IW'(exp_id[n]), addr: 32'h100 * (exp_id[n] + 1), len: 8'd0, size: 3'd2, burst: INCR});
      exp_vec = '0;
      exp_vec[exp_id[n]] = 1'b1;
      wait_accept(vec, ok);
      tests_run++;
      if (!ok || vec !== exp_vec) begin
        tests_failed++;
        $display("FAIL rr_grant%0d got=%b ok=%0d exp=%b", n, vec, ok, exp_vec);
      end
      cyc();
      @(negedge clk);
      e = ar_q.pop_front();
      tests_run++;
      if (m_arvalid !== 1'b1 || m_araddr !== e.addr || grant_id !== e.id) begin
        tests_failed++;
        $display("FAIL rr_ar%0d got arv=%b addr=%h gid=%0d exp addr=%h gid=%0d",
                 n, m_arvalid, m_araddr, grant_id, e.addr, e.id);
      end
      cyc();
      send_beat(64'(n), 1'b1);
      tests_run++;
      if (req_rvalid !== exp_vec) begin
        tests_failed++;
        $display("FAIL rr_beat%0d got rv=%b exp=%b", n, req_rvalid, exp_vec);
      end
      cyc();
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
    end
    req_arvalid = '0;
    cyc();
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] vec;
    bit ok;
    ar_exp_t e;
    // rr_ptr is 1 after the round-robin scenario; requester 2 is alone.
    m_arready = 1'b0;
    e = '{id: 2'd2, addr: 32'h2222_0000, len: 8'd3, size: 3'd2, burst: WRAP};
    ar_q.push_back(e);
    set_req(2, 32'h2222_0000, 8'd3, 3'd2, WRAP);
    wait_accept(vec, ok);
    tests_run++;
    if (!ok || vec !== 4'b0100) begin
      tests_failed++;
      $display("FAIL bp_arready got=%b ok=%0d exp=0100", vec, ok);
    end
    cyc();
    req_arvalid[2] = 1'b0;
    e = ar_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      req_araddr[2*AW +: AW] = 32'hBAD0_0000 + 32'(k);
      req_arlen[2*8 +: 8]    = 8'hFF;
      @(negedge clk);
      tests_run++;
      if (m_arvalid !== 1'b1 || m_araddr !== e.addr || m_arlen !== e.len ||
          m_arsize !== e.size || m_arburst !== e.burst) begin
        tests_failed++;
        $display("FAIL bp_ar_hold%0d got arv=%b addr=%h len=%0d size=%0d burst=%0d exp addr=%h len=%0d",
                 k, m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, e.addr, e.len);
      end
      cyc();
    end
    m_arready = 1'b1;
    cyc();
    send_beat(64'h10, 1'b0);
    cyc();
    req_rready[2] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      send_beat(64'h11, 1'b0);
      tests_run++;
      if (m_rready !== 1'b0 || req_rvalid !== 4'b0100 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_r_stall%0d got mrr=%b rv=%b busy=%b exp 0 0100 1", k, m_rready, req_rvalid, busy);
      end
      cyc();
    end
    req_rready[2] = 1'b1;
    send_beat(64'h11, 1'b0);
    cyc();
    send_beat(64'h12, 1'b0);
    cyc();
    send_beat(64'h13, 1'b1);
    cyc();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || proto_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_end got busy=%b err=%b exp 0 0", busy, proto_err);
    end
    cyc();
  endtask

  task automatic test_simultaneous();
    logic [NREQ-1:0] vec;
    bit ok;
    // rr_ptr is 3; requester 1 alone wins, leaving rr_ptr=2 afterwards.
    set_req(1, 32'h5000, 8'd1, 3'd3, INCR);
    wait_accept(vec, ok);
    cyc();
    req_arvalid[1] = 1'b0;
    cyc();
    send_beat(64'h50, 1'b0);
    cyc();
    set_req(0, 32'h6000, 8'd0, 3'd3, INCR);
    set_req(3, 32'h7000, 8'd0, 3'd3, INCR);
    send_beat(64'h51, 1'b1);
    tests_run++;
    if (req_arready !== '0 || req_rvalid !== 4'b0010) begin
      tests_failed++;
      $display("FAIL sim_rlast_cycle got arr=%b rv=%b exp 0000 0010", req_arready, req_rvalid);
    end
    cyc();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    @(negedge clk);
    tests_run++;
    if (req_arready !== 4'b1000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL sim_next_grant got arr=%b busy=%b exp 1000 0", req_arready, busy);
    end
    cyc();
    req_arvalid[3] = 1'b0;
    @(negedge clk);
    tests_run++;
    if (m_araddr !== 32'h7000 || grant_id !== 2'd3) begin
      tests_failed++;
      $display("FAIL sim_ar got addr=%h gid=%0d exp 7000 3", m_araddr, grant_id);
    end
    cyc();
    drive_beats(1);
    wait_accept(vec, ok);
    tests_run++;
    if (!ok || vec !== 4'b0001) begin
      tests_failed++;
      $display("FAIL sim_then_req0 got=%b ok=%0d exp=0001", vec, ok);
    end
    cyc();
    req_arvalid[0] = 1'b0;
    cyc();
    drive_beats(1);
  endtask

  task automatic test_proto_err();
    logic [NREQ-1:0] vec;
    bit ok;
    do_reset();
    // Early rlast: arlen=3 but rlast on beat 2.
    set_req(0, 32'h8000, 8'd3, 3'd3, INCR);
    wait_accept(vec, ok);
    cyc();
    req_arvalid[0] = 1'b0;
    cyc();
    send_beat(64'h80, 1'b0);
    cyc();
    send_beat(64'h81, 1'b1);
    tests_run++;
    if (proto_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL perr_early_pre got err=%b exp 0", proto_err);
    end
    cyc();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || proto_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL perr_early got busy=%b err=%b exp 0 1", busy, proto_err);
    end
    cyc();
    do_reset();
    // Overrun: arlen=1 but three beats, rlast on the third.
    set_req(1, 32'h9000, 8'd1, 3'd3, INCR);
    wait_accept(vec, ok);
    cyc();
    req_arvalid[1] = 1'b0;
    cyc();
    send_beat(64'h90, 1'b0);
    cyc();
    send_beat(64'h91, 1'b0);
    cyc();
    send_beat(64'h92, 1'b1);
    tests_run++;
    if (proto_err !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL perr_overrun got err=%b busy=%b exp 1 1", proto_err, busy);
    end
    cyc();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || proto_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL perr_overrun_exit got busy=%b err=%b exp 0 1", busy, proto_err);
    end
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    logic [NREQ-1:0] vec;
    bit ok;
    // rr_ptr is 2; without a reset a 1+3 contest afterwards would go to 3.
    set_req(2, 32'hA000, 8'd7, 3'd3, INCR);
    wait_accept(vec, ok);
    cyc();
    req_arvalid[2] = 1'b0;
    cyc();
    drive_beats(2);
    m_rvalid = 1'b1;
    m_rdata  = 64'hAA;
    m_rlast  = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if ({busy, m_arvalid, m_rready, req_rvalid, req_arready, grant_id, proto_err} !== '0 || m_araddr !== '0) begin
      tests_failed++;
      $display("FAIL rst_async got busy=%b arv=%b mrr=%b rv=%b gid=%0d addr=%h err=%b exp all 0",
               busy, m_arvalid, m_rready, req_rvalid, grant_id, m_araddr, proto_err);
    end
    m_rvalid = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
    set_req(1, 32'hB100, 8'd0, 3'd3, INCR);
    set_req(3, 32'hB300, 8'd0, 3'd3, INCR);
    wait_accept(vec, ok);
    tests_run++;
    if (!ok || vec !== 4'b0010) begin
      tests_failed++;
      $display("FAIL rst_regrant got=%b ok=%0d exp=0010", vec, ok);
    end
    cyc();
    req_arvalid = '0;
    @(negedge clk);
    tests_run++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'hB100) begin
      tests_failed++;
      $display("FAIL rst_regrant_ar got arv=%b addr=%h exp 1 b100", m_arvalid, m_araddr);
    end
    cyc();
    drive_beats(1);
  endtask

  initial begin
    resetn      = 1'b0;
    req_araddr  = '0;
    req_arlen   = '0;
    req_arsize  = '0;
    req_arburst = '0;
    req_arvalid = '0;
    req_rready  = '1;
    m_arready   = 1'b1;
    m_rdata     = '0;
    m_rlast     = 1'b0;
    m_rvalid    = 1'b0;
    cyc();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_simultaneous();
    test_proto_err();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
